// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register word indices, default window base
// and the active-low hex-to-7-segment table.
package mmio_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FC00;
  localparam logic [31:0] WINDOW_LAST       = 32'h0000_03FF;

  // Register word indices (byte offset >> 2)
  localparam logic [7:0] WORD_SW  = 8'h00;
  localparam logic [7:0] WORD_BTN = 8'h01;
  localparam logic [7:0] WORD_LED = 8'h02;
  localparam logic [7:0] WORD_SEG = 8'h03;
  localparam logic [7:0] WORD_CYC = 8'h04;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/mmio_responder_btn_debounce.sv
// One button: two-flop synchroniser, stability counter, accepted level and a
// single-cycle pulse on an accepted 0->1 transition.
module mmio_responder_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             meta;
  logic             sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Counter only runs while the synchronised input disagrees with the accepted level
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync;
        cnt   <= '0;
        rise  <= sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped board I/O slave: switches, sticky debounced buttons, LEDs,
// scanned 8-digit 7-segment display and a free-running cycle counter.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_SW       = 16,
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned DEBOUNCE_CYC = 200000,
  parameter int unsigned SCAN_DIV     = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [31:0]        addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic               io_sel,
  input  logic [NUM_SW-1:0]  switches,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [15:0]        leds,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_data
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [7:0]         word;
  logic               rd;
  logic               wr;
  logic [31:0]        rdata_c;
  logic [NUM_SW-1:0]  sw_meta;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] press_flags;
  logic [15:0]        led_q;
  logic [31:0]        seg_q;
  logic [31:0]        cycles_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;

  assign io_sel = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + WINDOW_LAST);
  assign word   = 8'((addr - BASE_ADDR) >> 2);
  assign rd     = MemRead && io_sel;
  assign wr     = MemWrite && io_sel;
  assign leds   = led_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    mmio_responder_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(buttons[i]),
      .rise   (rise_vec[i])
    );
  end

  // Read mux over pre-edge register values
  always_comb begin
    rdata_c = '0;
    case (word)
      WORD_SW:  rdata_c = 32'(sw_sync);
      WORD_BTN: rdata_c = 32'(press_flags);
      WORD_LED: rdata_c = {16'h0000, led_q};
      WORD_SEG: rdata_c = seg_q;
      WORD_CYC: rdata_c = cycles_q;
      default:  rdata_c = '0;
    endcase
  end

  // Bus-visible state; a new press outranks a same-cycle read-clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout        <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      press_flags <= '0;
      led_q       <= '0;
      seg_q       <= '0;
      cycles_q    <= '0;
    end else begin
      sw_meta     <= switches;
      sw_sync     <= sw_meta;
      press_flags <= (press_flags & ~{NUM_BTN{rd && (word == WORD_BTN)}}) | rise_vec;
      cycles_q    <= (wr && (word == WORD_CYC)) ? '0 : cycles_q + 32'd1;
      if (rd) begin
        dout <= rdata_c;
      end
      if (wr && (word == WORD_LED)) begin
        led_q <= din[15:0];
      end
      if (wr && (word == WORD_SEG)) begin
        seg_q <= din;
      end
    end
  end

  // Digit scan: each digit held for SCAN_DIV cycles, outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      seg_an    <= 8'hFE;
      seg_data  <= 8'hC0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      seg_an   <= ~(8'b0000_0001 << digit_idx);
      seg_data <= {1'b1, hex7(seg_q[{digit_idx, 2'b00} +: 4])};
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with short debounce and scan periods.
module tb_mmio_responder;

  localparam logic [31:0] A_SW  = 32'hFFFF_FC00;
  localparam logic [31:0] A_BTN = 32'hFFFF_FC04;
  localparam logic [31:0] A_LED = 32'hFFFF_FC08;
  localparam logic [31:0] A_SEG = 32'hFFFF_FC0C;
  localparam logic [31:0] A_CYC = 32'hFFFF_FC10;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        io_sel;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic [15:0] leds;
  logic [7:0]  seg_an;
  logic [7:0]  seg_data;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] rdv;

  mmio_responder #(
    .BASE_ADDR   (32'hFFFF_FC00),
    .NUM_SW      (16),
    .NUM_BTN     (5),
    .DEBOUNCE_CYC(8),
    .SCAN_DIV    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .io_sel  (io_sel),
    .switches(switches),
    .buttons (buttons),
    .leds    (leds),
    .seg_an  (seg_an),
    .seg_data(seg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0;
    d = dout;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    n_total++; if (dout !== 32'h0) $display("FAIL reset_dout got %h expected %h", dout, 32'h0); else n_pass++;
    n_total++; if (leds !== 16'h0) $display("FAIL reset_leds got %h expected %h", leds, 16'h0); else n_pass++;
    n_total++; if (seg_an !== 8'hFE) $display("FAIL reset_seg_an got %h expected %h", seg_an, 8'hFE); else n_pass++;
    n_total++; if (seg_data !== 8'hC0) $display("FAIL reset_seg_data got %h expected %h", seg_data, 8'hC0); else n_pass++;
    rst = 1'b1;
    bus_read(A_CYC, rdv);
    n_total++; if (!(rdv < 32'd4)) $display("FAIL reset_cycles got %h expected below 4", rdv); else n_pass++;
  endtask

  task automatic test_decode();
    addr = A_LED; #1;
    n_total++; if (io_sel !== 1'b1) $display("FAIL decode_led got %b expected 1", io_sel); else n_pass++;
    addr = 32'hFFFF_FFFC; #1;
    n_total++; if (io_sel !== 1'b1) $display("FAIL decode_top got %b expected 1", io_sel); else n_pass++;
    addr = 32'hFFFF_FBFC; #1;
    n_total++; if (io_sel !== 1'b0) $display("FAIL decode_below got %b expected 0", io_sel); else n_pass++;
    addr = 32'h0000_1234; #1;
    n_total++; if (io_sel !== 1'b0) $display("FAIL decode_low got %b expected 0", io_sel); else n_pass++;
  endtask

  task automatic test_sw();
    switches = 16'h3C5A;
    cyc(2);
    bus_read(A_SW, rdv);
    n_total++; if (rdv !== 32'h0000_3C5A) $display("FAIL sw_read got %h expected %h", rdv, 32'h0000_3C5A); else n_pass++;
  endtask

  task automatic test_led();
    bus_write(A_LED, 32'h0001_A5A5);
    n_total++; if (leds !== 16'hA5A5) $display("FAIL led_out got %h expected %h", leds, 16'hA5A5); else n_pass++;
    bus_read(A_LED, rdv);
    n_total++; if (rdv !== 32'h0000_A5A5) $display("FAIL led_read got %h expected %h", rdv, 32'h0000_A5A5); else n_pass++;
    bus_read(32'hFFFF_FC0B, rdv);
    n_total++; if (rdv !== 32'h0000_A5A5) $display("FAIL led_byte_offset got %h expected %h", rdv, 32'h0000_A5A5); else n_pass++;
  endtask

  task automatic test_unmapped();
    bus_write(32'hFFFF_FC20, 32'hFFFF_FFFF);
    bus_read(32'hFFFF_FC20, rdv);
    n_total++; if (rdv !== 32'h0) $display("FAIL unmapped_read got %h expected %h", rdv, 32'h0); else n_pass++;
  endtask

  task automatic test_outside();
    bus_read(A_LED, rdv);
    addr = 32'h0000_1234; din = 32'h0000_1234; MemWrite = 1'b1; #1;
    n_total++; if (io_sel !== 1'b0) $display("FAIL outside_io_sel got %b expected 0", io_sel); else n_pass++;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    n_total++; if (leds !== 16'hA5A5) $display("FAIL outside_leds got %h expected %h", leds, 16'hA5A5); else n_pass++;
    bus_read(32'h0000_1234, rdv);
    n_total++; if (rdv !== 32'h0000_A5A5) $display("FAIL outside_dout_hold got %h expected %h", rdv, 32'h0000_A5A5); else n_pass++;
  endtask

  task automatic test_read_before_write();
    addr = A_LED; din = 32'h0000_1111; MemRead = 1'b1; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    n_total++; if (dout !== 32'h0000_A5A5) $display("FAIL rbw_dout got %h expected %h", dout, 32'h0000_A5A5); else n_pass++;
    n_total++; if (leds !== 16'h1111) $display("FAIL rbw_leds got %h expected %h", leds, 16'h1111); else n_pass++;
  endtask

  task automatic test_seg();
    bus_write(A_SEG, 32'h7654_3210);
    bus_read(A_SEG, rdv);
    n_total++; if (rdv !== 32'h7654_3210) $display("FAIL seg_read got %h expected %h", rdv, 32'h7654_3210); else n_pass++;
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    logic [7:0] seg_tab [8];
    bit found;
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seg_an == 8'hFE) begin found = 1'b1; break; end
      cyc(1);
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc(1);
        if (seg_an != 8'hFE) begin found = 1'b1; break; end
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL scan_sync got seg_an %h expected digit transition within bound", seg_an);
    end else begin
      for (int k = 1; k <= 8; k++) begin
        exp_an = ~(8'h01 << (k % 8));
        n_total++; if (seg_an !== exp_an) $display("FAIL scan_an_%0d got %h expected %h", k, seg_an, exp_an); else n_pass++;
        n_total++; if (seg_data !== seg_tab[k % 8]) $display("FAIL scan_data_%0d got %h expected %h", k, seg_data, seg_tab[k % 8]); else n_pass++;
        cyc(4);
      end
    end
  endtask

  task automatic test_button();
    buttons[2] = 1'b1; cyc(1);
    buttons[2] = 1'b0; cyc(1);
    buttons[2] = 1'b1; cyc(1);
    cyc(16);
    bus_read(A_BTN, rdv);
    n_total++; if (rdv !== 32'h0000_0004) $display("FAIL btn_press got %h expected %h", rdv, 32'h0000_0004); else n_pass++;
    bus_read(A_BTN, rdv);
    n_total++; if (rdv !== 32'h0) $display("FAIL btn_reread got %h expected %h", rdv, 32'h0); else n_pass++;
    buttons[2] = 1'b0;
    cyc(16);
    bus_read(A_BTN, rdv);
    n_total++; if (rdv !== 32'h0) $display("FAIL btn_release got %h expected %h", rdv, 32'h0); else n_pass++;
  endtask

  task automatic test_set_wins();
    int hits;
    int other;
    hits = 0; other = 0;
    addr = A_BTN; MemRead = 1'b1;
    buttons[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (dout == 32'h1) hits++;
      else if (dout != 32'h0) other++;
    end
    MemRead = 1'b0;
    n_total++; if (hits !== 1) $display("FAIL set_wins_hits got %0d expected 1", hits); else n_pass++;
    n_total++; if (other !== 0) $display("FAIL set_wins_other got %0d expected 0", other); else n_pass++;
    buttons[0] = 1'b0;
    cyc(16);
  endtask

  task automatic test_cycles();
    bus_write(A_CYC, 32'hDEAD_BEEF);
    bus_read(A_CYC, rdv);
    n_total++; if (rdv !== 32'h0) $display("FAIL cycles_clear got %h expected %h", rdv, 32'h0); else n_pass++;
    cyc(5);
    bus_read(A_CYC, rdv);
    n_total++; if (rdv !== 32'd6) $display("FAIL cycles_count got %h expected %h", rdv, 32'd6); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    addr = '0; din = '0; switches = '0; buttons = '0;
    test_reset();
    test_decode();
    test_sw();
    test_led();
    test_unmapped();
    test_outside();
    test_read_before_write();
    test_seg();
    test_scan();
    test_button();
    test_set_wins();
    test_cycles();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
